fc_ibuf: RTL and testbench

// - Input buffer of an MLP layer. Sits directly downstream of the func stage of the previous layer.
// - Collects parallel element writes until the frame is complete.
// - Then streams the frame to this layer's CIM tiles, bit-serially (LSB first), one bit-plane per

---
 rtl/fc_ibuf.sv | 115 +++++++++++
 tb/tb_fc_ibuf.sv | 215 +++++++++++++++++++++
 2 files changed

// File: rtl/fc_ibuf.sv
// MLP layer input buffer: gathers parallel element writes into a frame, then streams
// the frame LSB-first as bit-planes spread across the vertical CIM tiles.
module fc_ibuf #(
    parameter int unsigned DATA_SIZE     = 8,
    parameter int unsigned INPUT_NEURONS = 512,
    parameter int unsigned XBAR_SIZE     = 256,
    parameter int unsigned WR_WIDTH      = 16,
    parameter int unsigned V_CIM_TILES   = (INPUT_NEURONS + XBAR_SIZE - 1) / XBAR_SIZE
) (
    input  logic                                    clk,
    input  logic                                    rst,
    input  logic                                    i_write_enable,
    input  logic [WR_WIDTH-1:0][DATA_SIZE-1:0]      i_data,
    input  logic                                    i_start,
    output logic                                    o_ready,
    input  logic                                    i_cim_ready,
    output logic                                    o_cim_valid,
    output logic [V_CIM_TILES-1:0][XBAR_SIZE-1:0]   o_cim_data,
    output logic [$clog2(DATA_SIZE):0]              o_cim_bit,
    output logic                                    o_cim_last
);

    localparam int unsigned WP_W  = $clog2(INPUT_NEURONS + 1);
    localparam int unsigned BIT_W = $clog2(DATA_SIZE) + 1;
    localparam int unsigned AW    = (INPUT_NEURONS > 1) ? $clog2(INPUT_NEURONS) : 1;
    localparam int unsigned WIW   = (WR_WIDTH > 1) ? $clog2(WR_WIDTH) : 1;

    typedef enum logic {
        S_IBUF_FILL,
        S_IBUF_STREAM
    } state_t;

    state_t               state;
    logic [WP_W-1:0]      wptr;
    logic [BIT_W-1:0]     bit_idx;
    logic [DATA_SIZE-1:0] buffer [INPUT_NEURONS];
    logic [DATA_SIZE-1:0] plane_mask;
    logic                 write_beat;
    logic                 final_plane;

    assign write_beat  = (state == S_IBUF_FILL) && i_write_enable;
    assign final_plane = (32'(bit_idx) == DATA_SIZE - 1);
    assign plane_mask  = DATA_SIZE'(1) << bit_idx;
    assign o_cim_bit   = bit_idx;

    always_ff @(posedge clk) begin
        if (rst) begin
            state       <= S_IBUF_FILL;
            wptr        <= '0;
            bit_idx     <= '0;
            o_ready     <= 1'b1;
            o_cim_valid <= 1'b0;
            o_cim_last  <= 1'b0;
        end else begin
            case (state)
                S_IBUF_FILL: begin
                    if (i_write_enable) begin
                        if (32'(wptr) + WR_WIDTH >= INPUT_NEURONS)
                            wptr <= WP_W'(INPUT_NEURONS);
                        else
                            wptr <= wptr + WP_W'(WR_WIDTH);
                    end
                    if (i_start) begin
                        state       <= S_IBUF_STREAM;
                        bit_idx     <= '0;
                        o_ready     <= 1'b0;
                        o_cim_valid <= 1'b1;
                        o_cim_last  <= (DATA_SIZE == 1);
                    end
                end
                S_IBUF_STREAM: begin
                    if (i_cim_ready) begin
                        if (final_plane) begin
                            state       <= S_IBUF_FILL;
                            wptr        <= '0;
                            bit_idx     <= '0;
                            o_ready     <= 1'b1;
                            o_cim_valid <= 1'b0;
                            o_cim_last  <= 1'b0;
                        end else begin
                            bit_idx    <= bit_idx + 1'b1;
                            // last flags the plane about to be presented, i.e. bit_idx+1
                            o_cim_last <= (32'(bit_idx) + 2 == DATA_SIZE);
                        end
                    end
                end
                default: state <= S_IBUF_FILL;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int unsigned j = 0; j < INPUT_NEURONS; j++)
                buffer[AW'(j)] <= '0;
        end else if (write_beat) begin
            for (int unsigned i = 0; i < WR_WIDTH; i++) begin
                if (32'(wptr) + i < INPUT_NEURONS)
                    buffer[AW'(32'(wptr) + i)] <= i_data[WIW'(i)];
            end
        end
    end

    // Rows past the end of the frame are tied low rather than read from the buffer.
    for (genvar t = 0; t < V_CIM_TILES; t++) begin : g_tile
        for (genvar r = 0; r < XBAR_SIZE; r++) begin : g_row
            if (t * XBAR_SIZE + r < INPUT_NEURONS) begin : g_live
                assign o_cim_data[t][r] = |(buffer[t * XBAR_SIZE + r] & plane_mask);
            end else begin : g_pad
                assign o_cim_data[t][r] = 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_fc_ibuf.sv
// Directed bench for fc_ibuf: default 512-element instance plus a 20-element overflow instance.
module tb_fc_ibuf;

    localparam int unsigned DS = 8;
    localparam int unsigned N  = 512;
    localparam int unsigned X  = 256;
    localparam int unsigned W  = 16;
    localparam int unsigned V  = 2;
    localparam int unsigned N2 = 20;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    logic                   we, start, cim_ready, ready, valid, last;
    logic [W-1:0][DS-1:0]   data;
    logic [V-1:0][X-1:0]    cim_data;
    logic [3:0]             cim_bit;

    logic                   we2, start2, cim_ready2, ready2, valid2, last2;
    logic [W-1:0][DS-1:0]   data2;
    logic [0:0][X-1:0]      cim_data2;
    logic [3:0]             cim_bit2;

    fc_ibuf #(.DATA_SIZE(8), .INPUT_NEURONS(512), .XBAR_SIZE(256), .WR_WIDTH(16)) dut (
        .clk(clk), .rst(rst), .i_write_enable(we), .i_data(data), .i_start(start),
        .o_ready(ready), .i_cim_ready(cim_ready), .o_cim_valid(valid),
        .o_cim_data(cim_data), .o_cim_bit(cim_bit), .o_cim_last(last)
    );

    fc_ibuf #(.DATA_SIZE(8), .INPUT_NEURONS(20), .XBAR_SIZE(256), .WR_WIDTH(16)) dut_ovf (
        .clk(clk), .rst(rst), .i_write_enable(we2), .i_data(data2), .i_start(start2),
        .o_ready(ready2), .i_cim_ready(cim_ready2), .o_cim_valid(valid2),
        .o_cim_data(cim_data2), .o_cim_bit(cim_bit2), .o_cim_last(last2)
    );

    int unsigned n_checks = 0;
    int unsigned n_fail   = 0;
    logic [7:0]  model [N];
    logic [7:0]  exp2  [N2];

    task automatic check(input string tag, input logic [511:0] got, input logic [511:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [511:0] plane(input int unsigned b);
        logic [511:0] p;
        p = '0;
        for (int unsigned e = 0; e < N; e++) p[e] = model[e][b[2:0]];
        return p;
    endfunction

    task automatic beat(input logic [W-1:0][DS-1:0] d, input logic with_start);
        data  = d;
        we    = 1'b1;
        start = with_start;
        tick();
        we    = 1'b0;
        start = 1'b0;
    endtask

    task automatic pulse_start();
        start = 1'b1;
        tick();
        start = 1'b0;
    endtask

    task automatic run_stream(input logic bp, input logic ign);
        int unsigned b   = 0;
        int unsigned cyc = 0;
        logic        pat [4] = '{1'b1, 1'b0, 1'b0, 1'b1};
        while (b < DS && cyc < 64) begin
            cim_ready = bp ? pat[cyc % 4] : 1'b1;
            if (ign) begin
                we    = 1'b1;
                start = 1'b1;
                data  = {W{8'h5A}};
            end
            check("valid",     512'(valid),   512'(1));
            check("ready_low", 512'(ready),   512'(0));
            check("bit",       512'(cim_bit), 512'(b));
            check("last",      512'(last),    512'(b == DS - 1));
            check("plane",     cim_data,      plane(b));
            tick();
            if (cim_ready) b++;
            cyc++;
        end
        we        = 1'b0;
        start     = 1'b0;
        cim_ready = 1'b1;
        check("stream_done", 512'(b),     512'(DS));
        check("ready_back",  512'(ready), 512'(1));
        check("valid_off",   512'(valid), 512'(0));
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        logic [W-1:0][DS-1:0] d;
        logic [511:0]         exp;
        int unsigned          k;

        rst = 1'b1; we = 1'b0; start = 1'b0; cim_ready = 1'b1; data = '0;
        we2 = 1'b0; start2 = 1'b0; cim_ready2 = 1'b1; data2 = '0;
        for (int unsigned e = 0; e < N; e++) model[e] = 8'h00;
        repeat (3) tick();
        rst = 1'b0;

        check("rst_ready", 512'(ready),   512'(1));
        check("rst_valid", 512'(valid),   512'(0));
        check("rst_last",  512'(last),    512'(0));
        check("rst_bit",   512'(cim_bit), 512'(0));
        check("rst_data",  cim_data,      512'(0));
        check("rst_ready2", 512'(ready2), 512'(1));

        // Overflow instance: beat 2 keeps elements 0..3 only, beat 3 is dropped.
        for (int unsigned i = 0; i < N2; i++)
            exp2[i] = (i < 16) ? 8'(8'h10 + i) : 8'(8'h80 + i - 16);
        for (int unsigned bt = 0; bt < 3; bt++) begin
            for (int unsigned i = 0; i < W; i++)
                data2[i] = (bt == 0) ? 8'(8'h10 + i) : (bt == 1) ? 8'(8'h80 + i) : 8'hEE;
            we2 = 1'b1;
            tick();
            we2 = 1'b0;
        end
        start2 = 1'b1;
        tick();
        start2 = 1'b0;
        for (int unsigned b = 0; b < DS; b++) begin
            exp = '0;
            for (int unsigned r = 0; r < N2; r++) exp[r] = exp2[r][b[2:0]];
            check("ovf_valid", 512'(valid2),    512'(1));
            check("ovf_bit",   512'(cim_bit2),  512'(b));
            check("ovf_last",  512'(last2),     512'(b == DS - 1));
            check("ovf_plane", 512'(cim_data2), exp);
            tick();
        end
        check("ovf_ready", 512'(ready2), 512'(1));
        check("ovf_valid_off", 512'(valid2), 512'(0));

        // Full frame, element k = k mod 256.
        for (int unsigned bt = 0; bt < 32; bt++) begin
            for (int unsigned i = 0; i < W; i++) begin
                k = bt * W + i;
                d[i] = 8'(k & 255);
                model[k] = 8'(k & 255);
            end
            beat(d, 1'b0);
        end
        check("fill_ready", 512'(ready), 512'(1));
        check("fill_valid", 512'(valid), 512'(0));
        pulse_start();
        run_stream(1'b0, 1'b0);

        // Restart without rewriting: buffer retained, stream under back-pressure.
        pulse_start();
        run_stream(1'b1, 1'b0);

        // New frame with the final beat of 0xFF carried alongside i_start.
        for (int unsigned bt = 0; bt < 32; bt++) begin
            for (int unsigned i = 0; i < W; i++) begin
                k = bt * W + i;
                d[i] = (bt == 31) ? 8'hFF : 8'((k * 3 + 1) & 255);
                model[k] = d[i];
            end
            beat(d, bt == 31);
        end
        run_stream(1'b0, 1'b1);
        pulse_start();
        run_stream(1'b0, 1'b0);

        // Reset while plane 3 is on the bus.
        pulse_start();
        repeat (3) tick();
        check("pre_rst_bit", 512'(cim_bit), 512'(3));
        rst = 1'b1;
        tick();
        rst = 1'b0;
        for (int unsigned e = 0; e < N; e++) model[e] = 8'h00;
        check("mid_rst_valid", 512'(valid),   512'(0));
        check("mid_rst_ready", 512'(ready),   512'(1));
        check("mid_rst_bit",   512'(cim_bit), 512'(0));
        check("mid_rst_last",  512'(last),    512'(0));
        check("mid_rst_data",  cim_data,      512'(0));
        tick();
        check("mid_rst_quiet", 512'(valid),   512'(0));
        for (int unsigned bt = 0; bt < 2; bt++) begin
            for (int unsigned i = 0; i < W; i++) begin
                k = bt * W + i;
                d[i] = 8'((k + 7) & 255);
                model[k] = d[i];
            end
            beat(d, 1'b0);
        end
        pulse_start();
        run_stream(1'b0, 1'b0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
